// File: rtl/uart_xcvr_pkg.sv
// ----------------------------------------------------------------------------
// uart_xcvr_pkg
// Shared types and constants for the uart_xcvr transceiver.
//   tx_state_e / rx_state_e : FSM state encodings
//   FRAME_BITS              : bits per frame on the line (start + data + [parity] + stop)
//   cnt_width()             : width of the per-bit cycle counter
// Optional feature macro: UART_XCVR_PARITY_EN (adds an even-parity bit to each frame).
// ----------------------------------------------------------------------------
package uart_xcvr_pkg;

`ifdef UART_XCVR_PARITY_EN
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    localparam int FRAME_BITS = 10;
`endif

    // Counter spans 0 .. cycles_per_bit-1; guard the degenerate case so the
    // width is never zero.
    function automatic int cnt_width(input int cycles_per_bit);
        cnt_width = (cycles_per_bit > 2) ? $clog2(cycles_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_xcvr_rx.sv
// ----------------------------------------------------------------------------
// uart_xcvr_rx
// Receive half of the UART: 2-flop synchronizer, RX FSM and a one-entry
// output register with valid/ready handshake.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   rx_i                 : asynchronous serial input
//   rx_data_o/rx_valid_o : received byte and its valid flag
//   rx_ready_i           : consumer accepts rx_data_o
//   rx_overflow_o        : pulse, new byte dropped because register was full
//   rx_frame_err_o       : pulse, stop bit sampled low
//   rx_parity_err_o      : pulse, parity mismatch (constant 0 unless
//                          UART_XCVR_PARITY_EN is defined)
// ----------------------------------------------------------------------------
module uart_xcvr_rx
    import uart_xcvr_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       rx_overflow_o,
    output logic       rx_frame_err_o,
    output logic       rx_parity_err_o
);

    localparam int                CNT_W    = cnt_width(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);

    logic             rx_meta_q;
    logic             rx_s_q;
    logic             rx_prev_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             overflow_q;
    logic             frame_err_q;
    logic             bit_end;
    logic             parity_bad;

    // Synchronizer plus one extra stage for falling-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);
    assign cnt_d   = bit_end ? '0 : cnt_q + 1'b1;

`ifdef UART_XCVR_PARITY_EN
    logic par_bit_q;
    logic parity_err_q;
    assign parity_bad      = ((^shift_q) != par_bit_q);
    assign rx_parity_err_o = parity_err_q;
`else
    assign parity_bad      = 1'b0;
    assign rx_parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_XCVR_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_XCVR_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // Consumer read; a byte completing this same cycle re-sets valid below.
            if (rx_ready_i && valid_q) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_s_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // A line already back high at mid-start is a glitch.
                        state_q   <= rx_s_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_XCVR_PARITY_EN
                            state_q <= RX_PARITY;
`else
                            state_q <= RX_STOP;
`endif
                        end
                    end
                end
`ifdef UART_XCVR_PARITY_EN
                RX_PARITY: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        par_bit_q <= rx_s_q;
                        state_q   <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        if (!rx_s_q) begin
                            // Frame error wins over any parity result.
                            frame_err_q <= 1'b1;
                            state_q     <= RX_BREAK;
                        end else begin
                            // Leave at bit centre so the next start edge is caught early.
                            state_q <= RX_IDLE;
                            if (parity_bad) begin
`ifdef UART_XCVR_PARITY_EN
                                parity_err_q <= 1'b1;
`endif
                            end else if (!valid_q || rx_ready_i) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end
                    end
                end
                RX_BREAK: begin
                    // Hold here while the line stays low so a break reports once.
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= RX_IDLE;
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rx_data_o      = data_q;
    assign rx_valid_o     = valid_q;
    assign rx_overflow_o  = overflow_q;
    assign rx_frame_err_o = frame_err_q;

endmodule

// File: rtl/uart_xcvr.sv
// ----------------------------------------------------------------------------
// uart_xcvr
// 8N1 UART transceiver (8E1 when UART_XCVR_PARITY_EN is defined).
// The TX FSM lives here; the receive path is in uart_xcvr_rx.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   tx_data_i/tx_valid_i : byte to send and its valid flag
//   tx_ready_o           : transmitter idle, accepts a byte
//   tx_o                 : serial output, idle high
//   rx_i                 : serial input (asynchronous)
//   rx_data_o/rx_valid_o : received byte and its valid flag
//   rx_ready_i           : consumer accepts rx_data_o
//   rx_overflow_o, rx_frame_err_o, rx_parity_err_o : one-cycle error pulses
// Optional feature macro: UART_XCVR_PARITY_EN.
// ----------------------------------------------------------------------------
module uart_xcvr
    import uart_xcvr_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       rx_overflow_o,
    output logic       rx_frame_err_o,
    output logic       rx_parity_err_o
);

    localparam int                CYCLES_PER_BIT = CLK_FREQ / BAUD;
    localparam int                CNT_W          = cnt_width(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(CYCLES_PER_BIT - 1);

    if (CYCLES_PER_BIT < 4) begin : g_cpb_check
        $error("uart_xcvr: CLK_FREQ/BAUD must be at least 4");
    end

    tx_state_e        tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [CNT_W-1:0] tx_cnt_d;
    logic [2:0]       tx_bit_idx_q;
    logic [2:0]       tx_next_idx;
    logic [7:0]       tx_data_q;
    logic             tx_q;
    logic             tx_ready_q;
    logic             tx_bit_end;

    assign tx_bit_end  = (tx_cnt_q == CNT_LAST);
    assign tx_cnt_d    = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    assign tx_next_idx = tx_bit_idx_q + 3'd1;

    // Line level and ready are registered so tx_o is glitch-free at the pad.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_idx_q <= '0;
            tx_data_q    <= '0;
            tx_q         <= 1'b1;
            tx_ready_q   <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_cnt_q <= '0;
                    if (tx_valid_i) begin
                        tx_data_q  <= tx_data_i;
                        tx_state_q <= TX_START;
                        tx_q       <= 1'b0;
                        tx_ready_q <= 1'b0;
                    end
                end
                TX_START: begin
                    tx_cnt_q <= tx_cnt_d;
                    if (tx_bit_end) begin
                        tx_state_q   <= TX_DATA;
                        tx_bit_idx_q <= '0;
                        tx_q         <= tx_data_q[0];
                    end
                end
                TX_DATA: begin
                    tx_cnt_q <= tx_cnt_d;
                    if (tx_bit_end) begin
                        tx_bit_idx_q <= tx_next_idx;
                        if (tx_bit_idx_q == 3'd7) begin
`ifdef UART_XCVR_PARITY_EN
                            tx_state_q <= TX_PARITY;
                            tx_q       <= ^tx_data_q;
`else
                            tx_state_q <= TX_STOP;
                            tx_q       <= 1'b1;
`endif
                        end else begin
                            tx_q <= tx_data_q[tx_next_idx];
                        end
                    end
                end
`ifdef UART_XCVR_PARITY_EN
                TX_PARITY: begin
                    tx_cnt_q <= tx_cnt_d;
                    if (tx_bit_end) begin
                        tx_state_q <= TX_STOP;
                        tx_q       <= 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    tx_cnt_q <= tx_cnt_d;
                    if (tx_bit_end) begin
                        tx_state_q <= TX_IDLE;
                        tx_ready_q <= 1'b1;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    tx_cnt_q   <= '0;
                    tx_q       <= 1'b1;
                    tx_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = tx_ready_q;

    uart_xcvr_rx #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT)
    ) u_rx (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .rx_i            (rx_i),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready_i),
        .rx_overflow_o   (rx_overflow_o),
        .rx_frame_err_o  (rx_frame_err_o),
        .rx_parity_err_o (rx_parity_err_o)
    );

endmodule

// File: tb/tb_uart_xcvr.sv
// ----------------------------------------------------------------------------
// tb_uart_xcvr
// Directed bench for uart_xcvr at 16 clocks per bit (1.6 MHz / 100 kbit/s).
// Inputs change on the falling clock edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_uart_xcvr;

    localparam int CPB = 16;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic       tx_o;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i = 1'b1;
    logic       rx_overflow_o;
    logic       rx_frame_err_o;
    logic       rx_parity_err_o;

    logic       loopback = 1'b0;
    logic       rx_drv = 1'b1;
    assign rx_i = loopback ? tx_o : rx_drv;

    uart_xcvr #(
        .CLK_FREQ (1_600_000),
        .BAUD     (100_000)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .tx_data_i       (tx_data_i),
        .tx_valid_i      (tx_valid_i),
        .tx_ready_o      (tx_ready_o),
        .tx_o            (tx_o),
        .rx_i            (rx_i),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready_i),
        .rx_overflow_o   (rx_overflow_o),
        .rx_frame_err_o  (rx_frame_err_o),
        .rx_parity_err_o (rx_parity_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Cycle counter and output monitor (each variable has a single writer).
    int         cyc = 0;
    always @(posedge clk_i) cyc++;

    logic [7:0] rx_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         pe_cnt = 0;
    int         vrise_cnt = 0;
    logic       valid_prev = 1'b0;
    always @(negedge clk_i) begin
        if (rx_valid_o && rx_ready_i) rx_q.push_back(rx_data_o);
        if (rx_frame_err_o) fe_cnt++;
        if (rx_overflow_o) ov_cnt++;
        if (rx_parity_err_o) pe_cnt++;
        if (rx_valid_o && !valid_prev) vrise_cnt++;
        valid_prev = rx_valid_o;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Handshake one byte on the TX port; returns on the negedge after the accepting edge.
    int hs_cyc = 0;
    task automatic tx_send(input logic [7:0] b);
        int w;
        w = 0;
        while (!tx_ready_o && w < 400) begin
            @(negedge clk_i);
            w++;
        end
        if (!tx_ready_o) begin
            check("tx_ready_timeout", 32'(tx_ready_o), 32'd1);
        end else begin
            tx_data_i  = b;
            tx_valid_i = 1'b1;
            hs_cyc     = cyc;
            @(negedge clk_i);
            tx_valid_i = 1'b0;
            tx_data_i  = 8'hFF;
        end
    endtask

    task automatic rx_bit(input logic v);
        rx_drv = v;
        repeat (CPB) @(negedge clk_i);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop_bit);
    endtask

    // Watchdog: any hang ends the run with a failure line.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         ready_low;
        int         q0;
        int         fe0;
        int         ov0;
        int         vr0;
        int         hs_a;
        int         gap;
        logic [9:0] frame;
        logic [7:0] bytes3 [3];

        // ---------------- reset state ----------------
        idle(3);
        check("reset tx_o", 32'(tx_o), 32'd1);
        check("reset tx_ready", 32'(tx_ready_o), 32'd1);
        check("reset rx_valid", 32'(rx_valid_o), 32'd0);
        check("reset rx_data", 32'(rx_data_o), 32'h00);
        check("reset err pulses", {29'd0, rx_overflow_o, rx_frame_err_o, rx_parity_err_o}, 32'd0);
        rst_ni = 1'b1;
        idle(4);

        // ---------------- 1: TX waveform of 0xA5 ----------------
        // start 0, data LSB first 1,0,1,0,0,1,0,1, stop 1
        frame = 10'b1_10100101_0;
        tx_send(8'hA5);
        ready_low = 0;
        for (int i = 0; i < 200; i++) begin
            if (!tx_ready_o) ready_low++;
            if (i == 0) check("tx first cycle is start", 32'(tx_o), 32'd0);
            if (i < 160 && (i % CPB) == 8)
                check($sformatf("tx A5 bit %0d", i / CPB), 32'(tx_o), 32'(frame[i / CPB]));
            if (i == 159) check("tx last stop cycle", 32'(tx_o), 32'd1);
            @(negedge clk_i);
        end
        check("tx_ready low cycles", 32'(ready_low), 32'd160);
        check("tx idle line", 32'(tx_o), 32'd1);

        // ---------------- 2: loopback, back-to-back ----------------
        loopback   = 1'b1;
        rx_ready_i = 1'b1;
        idle(4);
        q0  = rx_q.size();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        bytes3[0] = 8'h00;
        bytes3[1] = 8'hFF;
        bytes3[2] = 8'h3C;
        tx_send(bytes3[0]);
        hs_a = hs_cyc;
        tx_send(bytes3[1]);
        gap = hs_cyc - hs_a;
        check("back-to-back handshake gap", 32'(gap), 32'd161);
        tx_send(bytes3[2]);
        idle(200);
        check("loopback byte count", 32'(rx_q.size() - q0), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("loopback byte %0d", i), 32'(rx_q[q0 + i]), 32'(bytes3[i]));
        check("loopback frame errors", 32'(fe_cnt - fe0), 32'd0);
        check("loopback overflows", 32'(ov_cnt - ov0), 32'd0);
        check("loopback parity errors", 32'(pe_cnt), 32'd0);
        loopback = 1'b0;
        rx_drv   = 1'b1;
        idle(10);

        // ---------------- 3: false start ----------------
        vr0 = vrise_cnt;
        fe0 = fe_cnt;
        rx_drv = 1'b0;
        idle(6);
        rx_drv = 1'b1;
        idle(40);
        check("false start valid", 32'(vrise_cnt - vr0), 32'd0);
        check("false start frame err", 32'(fe_cnt - fe0), 32'd0);

        // ---------------- 4: frame error then break, then good byte ----------------
        vr0 = vrise_cnt;
        fe0 = fe_cnt;
        q0  = rx_q.size();
        rx_frame(8'h55, 1'b0);
        idle(40);
        rx_bit(1'b1);
        check("break frame err count", 32'(fe_cnt - fe0), 32'd1);
        check("break no valid", 32'(vrise_cnt - vr0), 32'd0);
        rx_frame(8'h12, 1'b1);
        idle(20);
        check("after break byte count", 32'(rx_q.size() - q0), 32'd1);
        check("after break byte", 32'(rx_q[q0]), 32'h12);
        check("after break frame err", 32'(fe_cnt - fe0), 32'd1);

        // ---------------- 5: overflow ----------------
        rx_ready_i = 1'b0;
        idle(4);
        ov0 = ov_cnt;
        rx_frame(8'h11, 1'b1);
        idle(4);
        rx_frame(8'h22, 1'b1);
        idle(10);
        check("overflow valid held", 32'(rx_valid_o), 32'd1);
        check("overflow data kept", 32'(rx_data_o), 32'h11);
        check("overflow pulse count", 32'(ov_cnt - ov0), 32'd1);
        rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
        check("valid cleared by read", 32'(rx_valid_o), 32'd0);
        idle(4);
        rx_ready_i = 1'b1;

        // ---------------- 6: reset mid-frame ----------------
        tx_send(8'hC3);
        // C3 LSB first: 1,1,0,0,0,0,1,1 ; start + 3 bits in, tx is on data bit 2 (0)
        rx_bit(1'b0);
        rx_bit(1'b1);
        rx_bit(1'b1);
        idle(4);
        rx_drv = 1'b0;
        check("pre-reset tx_o", 32'(tx_o), 32'd0);
        check("pre-reset tx_ready", 32'(tx_ready_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        check("async reset tx_o", 32'(tx_o), 32'd1);
        check("async reset tx_ready", 32'(tx_ready_o), 32'd1);
        check("async reset rx_valid", 32'(rx_valid_o), 32'd0);
        rx_drv = 1'b1;
        idle(3);
        rst_ni = 1'b1;
        idle(20);
        q0  = rx_q.size();
        fe0 = fe_cnt;
        vr0 = vrise_cnt;
        rx_frame(8'h7E, 1'b1);
        idle(20);
        check("post-reset byte count", 32'(rx_q.size() - q0), 32'd1);
        check("post-reset byte", 32'(rx_q[q0]), 32'h7E);
        check("post-reset valid rises", 32'(vrise_cnt - vr0), 32'd1);
        check("post-reset frame err", 32'(fe_cnt - fe0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_xcvr.md
Name: uart_xcvr

Overview:
Synthesizable UART transceiver, 8N1 framing (8 data bits, no parity, 1 stop bit). It is the device-side counterpart of the simulation UART host model.
- Serializes bytes from a valid/ready byte interface onto tx_o.
- Deserializes rx_i into a one-entry output register with a valid/ready interface.
- Sits between a peripheral register block and the chip pads; bit rate is fixed at elaboration.

Parameters:
CLK_FREQ, 50_000_000, clock frequency in Hz.
BAUD, 115_200, line rate in bit/s.
CYCLES_PER_BIT, CLK_FREQ/BAUD, clock cycles per bit (localparam). Elaboration fails if it is below 4.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
tx_data_i  input  8  byte to send
tx_valid_i  input  1  tx_data_i valid
tx_ready_o  output  1  transmitter idle, can accept a byte
tx_o  output  1  serial line out, idle high
rx_i  input  1  serial line in (asynchronous)
rx_data_o  output  8  received byte
rx_valid_o  output  1  rx_data_o holds an unread byte
rx_ready_i  input  1  consumer accepts rx_data_o
rx_overflow_o  output  1  one-cycle pulse: byte dropped because the output register was full
rx_frame_err_o  output  1  one-cycle pulse: stop bit sampled low
rx_parity_err_o  output  1  one-cycle pulse: parity mismatch (0 without the optional feature)

Behaviour:
Reset values:
- tx_o=1, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, all error pulses 0.
- Both FSMs in IDLE; rx synchronizer flops=1.
- Reset asserted mid-frame aborts immediately. tx_o returns high asynchronously; the partial RX byte is discarded.

TX FSM (IDLE, START, DATA, STOP):
- Handshake: tx_valid_i && tx_ready_o latches tx_data_i. tx_ready_o is high only in IDLE.
- Cycle after the handshake: enter START, drive tx_o=0 for CYCLES_PER_BIT cycles.
- DATA: bits sent LSB first, each held CYCLES_PER_BIT cycles; 3-bit bit index.
- STOP: tx_o=1 for CYCLES_PER_BIT cycles, then IDLE. tx_ready_o rises on the first IDLE cycle.
- Back-to-back: a byte handshaken on the first IDLE cycle starts its START bit the next cycle, with no extra idle bit.
- Timing: frame = 10*CYCLES_PER_BIT cycles; handshake-to-next-handshake minimum is 10*CYCLES_PER_BIT+1 cycles.
- tx_data_i changes after the handshake have no effect.

RX path:
- rx_i passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- IDLE: a falling edge on rx_s (previous 1, current 0) enters START and clears the cycle counter.
- START: at counter == CYCLES_PER_BIT/2-1, sample rx_s.
  - 1: false start, back to IDLE, no error.
  - 0: enter DATA, clear counter.
- DATA: sample at counter == CYCLES_PER_BIT-1, i.e. bit centre. Shift in LSB first; after 8 samples enter STOP.
- STOP: sample at bit centre.
  - rx_s=1: byte complete, return to IDLE immediately, so the next start bit is detectable within half a bit.
  - rx_s=0: pulse rx_frame_err_o, drop the byte, enter BREAK.
- BREAK: wait for rx_s=1, then IDLE. A continuous low line yields exactly one frame error.

RX output register:
- On completion, if !rx_valid_o or rx_ready_i is high: load rx_data_o, set rx_valid_o the next cycle.
- Completion while rx_valid_o && !rx_ready_i: keep the old byte, pulse rx_overflow_o, drop the new byte.
- rx_ready_i && rx_valid_o with no completion: clear rx_valid_o.
- Latency: rx_valid_o rises 1 cycle after the stop-bit centre sample (plus 2 synchronizer cycles relative to rx_i).

Counter width: $clog2(CYCLES_PER_BIT) bits, no wrap beyond CYCLES_PER_BIT-1.

Optional Feature:
UART_XCVR_PARITY_EN defined:
- Even parity bit inserted between DATA and STOP. TX and RX FSMs gain a PARITY state; frame = 11 bits.
- RX mismatch: pulse rx_parity_err_o in the STOP-sample cycle, drop the byte.
- A frame error takes priority: only rx_frame_err_o pulses when both occur.

Undefined: no PARITY state, 10-bit frames, rx_parity_err_o tied 0.

Decomposition:
- Package uart_xcvr_pkg: tx_state_e and rx_state_e enums, FRAME_BITS constant (10 or 11 depending on macro), and a function computing counter width from CYCLES_PER_BIT.
- One natural sub-module, uart_xcvr_rx: synchronizer, RX FSM and output register. The TX FSM stays in the top.

Test Plan:
All scenarios use CLK_FREQ=1_600_000, BAUD=100_000, so CYCLES_PER_BIT=16.
1. Send 0xA5 via tx handshake -> tx_o: low 16 cycles, then bits 1,0,1,0,0,1,0,1 (16 cycles each), high 16 cycles; tx_ready_o low for exactly 160 cycles.
2. Loopback tx_o->rx_i with 0x00, 0xFF, 0x3C back-to-back, rx_ready_i=1 -> three rx_valid_o pulses carrying matching data; no error pulses.
3. rx_i low for 6 cycles then high -> no rx_valid_o and no errors (false start).
4. Frame 0x55 with stop bit driven 0, then line held low 40 cycles -> one rx_frame_err_o pulse; no rx_valid_o. A following good 0x12 frame is received correctly.
5. Two frames 0x11, 0x22 with rx_ready_i=0 -> rx_data_o stays 0x11 and rx_overflow_o pulses once. Then rx_ready_i=1 for one cycle -> rx_valid_o falls.
6. Assert rst_ni low mid-DATA of a TX 0xC3 and an RX frame -> tx_o=1 and tx_ready_o=1 asynchronously; rx_valid_o=0; a subsequent 0x7E frame is received cleanly.
